// File: rtl/maxpool_relu.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_relu
// Purpose  : Three-channel ReLU plus 2x2 stride-2 max pooling on a raster
//            stream, using a half-row buffer per channel instead of frame storage.
// Revision : 1.0  initial release
// ============================================================================
module maxpool_relu #(
    parameter int CONV_BIT       = 12,
    parameter int HALF_WIDTH     = 12,
    parameter int HALF_HEIGHT    = 12,
    parameter int HALF_WIDTH_BIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic signed [CONV_BIT-1:0] conv_out_1,
    input  logic signed [CONV_BIT-1:0] conv_out_2,
    input  logic signed [CONV_BIT-1:0] conv_out_3,
    output logic        [CONV_BIT-1:0] max_value_1,
    output logic        [CONV_BIT-1:0] max_value_2,
    output logic        [CONV_BIT-1:0] max_value_3,
    output logic                       valid_out_relu
);

    localparam int c_NCH    = 3;
    localparam int c_PCNT_W = HALF_WIDTH_BIT + 1;
    localparam int c_RCNT_W = $clog2(2 * HALF_HEIGHT);
    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(2 * HALF_WIDTH - 1);
    localparam logic [c_RCNT_W-1:0] c_RCNT_LAST = c_RCNT_W'(2 * HALF_HEIGHT - 1);

    logic [c_PCNT_W-1:0]       r_pcount;
    logic [c_RCNT_W-1:0]       r_rcount;
    logic                      r_valid;
    logic                      w_col_odd;
    logic                      w_row_odd;
    logic [HALF_WIDTH_BIT-1:0] w_idx;

    logic signed [CONV_BIT-1:0] w_sample [c_NCH];
    logic        [CONV_BIT-1:0] w_result [c_NCH];

    assign w_col_odd   = r_pcount[0];
    assign w_row_odd   = r_rcount[0];
    assign w_idx       = r_pcount[c_PCNT_W-1:1];
    assign w_sample[0] = conv_out_1;
    assign w_sample[1] = conv_out_2;
    assign w_sample[2] = conv_out_3;

    // Raster position; the wrap after the last row is the only frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcount <= '0;
            r_rcount <= '0;
        end else if (valid_in) begin
            if (r_pcount == c_PCNT_LAST) begin
                r_pcount <= '0;
                r_rcount <= (r_rcount == c_RCNT_LAST) ? '0 : r_rcount + c_RCNT_W'(1);
            end else begin
                r_pcount <= r_pcount + c_PCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= valid_in & w_row_odd & w_col_odd;
        end
    end

    for (genvar g = 0; g < c_NCH; g++) begin : g_chan
        logic signed [CONV_BIT-1:0] r_pair;
        logic signed [CONV_BIT-1:0] r_out;
        logic signed [CONV_BIT-1:0] r_buf [HALF_WIDTH];
        logic signed [CONV_BIT-1:0] w_buf_rd;
        logic signed [CONV_BIT-1:0] w_pair_max;
        logic signed [CONV_BIT-1:0] w_win_max;

        assign w_buf_rd   = r_buf[w_idx];
        assign w_pair_max = (w_sample[g] > r_pair) ? w_sample[g] : r_pair;
        assign w_win_max  = (w_buf_rd > w_pair_max) ? w_buf_rd : w_pair_max;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pair <= '0;
                r_out  <= '0;
            end else if (valid_in) begin
                if (!w_col_odd) begin
                    r_pair <= w_sample[g];
                end
                if (w_row_odd && w_col_odd) begin
                    r_out <= w_win_max[CONV_BIT-1] ? '0 : w_win_max;
                end
            end
        end

        // Holds the top-row pair maxima; stale contents are always overwritten
        // by the even row before the odd row reads them.
        always_ff @(posedge clk) begin
            if (valid_in && !w_row_odd && w_col_odd) begin
                r_buf[w_idx] <= w_pair_max;
            end
        end

        assign w_result[g] = r_out;
    end

    assign max_value_1    = w_result[0];
    assign max_value_2    = w_result[1];
    assign max_value_3    = w_result[2];
    assign valid_out_relu = r_valid;

endmodule
`default_nettype wire

// File: doc/maxpool_relu.md
# maxpool_relu

Downstream stage of the first convolution layer: consumes its three 12-bit signed channel streams and applies ReLU plus 2x2 stride-2 max pooling per channel. Each 24x24 channel map becomes a 12x12 map of non-negative values. A 12-entry half-row buffer per channel lets the block work on the raw stream, with no frame storage. Output feeds the second convolution buffer.

## Interface
Parameters:
- CONV_BIT, 12: width of each signed channel sample in and out.
- HALF_WIDTH, 12: pooled output columns; input row length is 2*HALF_WIDTH.
- HALF_HEIGHT, 12: pooled output rows; input frame height is 2*HALF_HEIGHT.
- HALF_WIDTH_BIT, 4: width of the half-row buffer index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  the three conv_out_* samples are valid this cycle.
- conv_out_1, conv_out_2, conv_out_3  in  CONV_BIT each  signed two's-complement conv results, one per channel.
- max_value_1, max_value_2, max_value_3  out  CONV_BIT each  pooled, ReLU'd result per channel; always >= 0.
- valid_out_relu  out  1  one-cycle strobe; max_value_* are valid.

## Operation
- Input order is a row-major 24x24 raster per frame. All three channels advance together; valid_in may be gapped arbitrarily, and samples count only on valid_in=1.
- Counters: pcount (column, 0..2*HALF_WIDTH-1) and rcount (row, 0..2*HALF_HEIGHT-1) advance only on valid_in.
  - pcount wraps to 0 at 23 and increments rcount.
  - rcount wraps to 0 after row 23 col 23, which starts the next frame. There is no idle or frame-start handshake.
- Per channel, on each valid_in:
  - Even rcount, even pcount: hold sample in pair register.
  - Even rcount, odd pcount: buffer[pcount>>1] <= signed max(pair register, sample).
  - Odd rcount, even pcount: hold sample in pair register.
  - Odd rcount, odd pcount: result = signed max(buffer[pcount>>1], pair register, sample). Register ReLU(result) to max_value_n and assert valid_out_relu.
- ReLU: if the sign bit is set, output 0; otherwise pass the value unchanged. Width stays CONV_BIT, with no saturation or truncation.
- Ties: any equal value is selected; the result is the same.
- The buffer is overwritten by the next even row. The buffer is not cleared between rows or frames, and this is not required.
- Outputs per frame: exactly HALF_WIDTH*HALF_HEIGHT = 144 strobes, in row-major pooled order.

## Timing
- Reset state: all max_value_* = 0, valid_out_relu = 0, pcount = 0, rcount = 0, pair registers = 0. Buffer contents are don't-care.
- Latency: valid_out_relu rises on the clock edge after the cycle in which the bottom-right sample of a 2x2 window (odd row, odd column) is presented with valid_in=1.
- valid_out_relu is high for exactly one cycle per window.
- max_value_* hold their last value when valid_out_relu=0.
- Maximum throughput is one input per cycle. Strobes are then spaced 2 cycles apart within odd rows, with none during even rows.
- Back-to-back frames: the first sample of frame N+1 may arrive the cycle after the last sample of frame N. The last window of frame N still strobes on the next edge.
- Reset mid-frame: outputs and counters clear asynchronously. After release, the next valid_in is treated as pixel (0,0) of a new frame. Any pending strobe is dropped.
- valid_in=0: no state changes and no strobe, even if inputs toggle.

## Test plan
- Ramp frame: channel 1 sample = row*24+col (no negatives), valid_in continuous -> 144 strobes. Pooled (r,c) = (2r+1)*24+2c+1; first output 25, last 575.
- All-negative frame: all channels -12 -> 144 strobes, all max_value_* = 0.
- Max in each window position: repeat with the single positive 100 placed at TL, TR, BL and BR of window (0,0), with all other values -5. Each case -> first output 100 and the remaining outputs 0. Run this per channel with distinct values so the three channels are checked independently.
- Gapped input: ramp frame with valid_in random at 40% duty -> identical output sequence to the continuous case. Each strobe comes exactly one cycle after its odd/odd sample.
- Back-to-back frames: two ramp frames with no gap; the second frame is offset +1000 and fits in 12 bits -> 288 strobes. The second frame's first output is 1025, with no leftover from frame 1's buffer.
- Mid-frame reset: assert rst_n=0 at row 7 col 10 -> outputs 0 immediately. Feed a fresh full frame -> 144 correct strobes starting at pooled (0,0).
